// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin arbiter sharing the single L2 request port between icache and dcache.
package l2_port_arbiter_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int L2_TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   ic_req_address,
  input  memory_operation_e ic_req_type,
  input  logic              ic_req_valid,
  input  logic [XLEN-1:0]   ic_word_to_store,
  output logic [XLEN-1:0]   ic_fetched_word,
  output logic              ic_fetched_word_valid,
  input  logic [XLEN-1:0]   dc_req_address,
  input  memory_operation_e dc_req_type,
  input  logic              dc_req_valid,
  input  logic [XLEN-1:0]   dc_word_to_store,
  output logic [XLEN-1:0]   dc_fetched_word,
  output logic              dc_fetched_word_valid,
  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_word_to_store,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_fetched_word_valid,
  output logic              l2_timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_e;
  localparam bit TO_EN = L2_TIMEOUT_CYCLES > 0;
  localparam int CW = TO_EN ? $clog2(L2_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(L2_TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [XLEN-1:0] ic_word_q, ic_word_d, dc_word_q, dc_word_d;
  memory_operation_e type_q, type_d;
  logic pick_dc;
  // owner/last_grant encode 1 = dcache; last_grant resets to icache so dcache wins the first tie
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    cnt_d = cnt_q;
    timeout_d = timeout_q;
    addr_d = addr_q;
    type_d = type_q;
    wdata_d = wdata_q;
    ic_word_d = ic_word_q;
    dc_word_d = dc_word_q;
    pick_dc = dc_req_valid && (!ic_req_valid || !last_q);
    case (state_q)
      IDLE: if (ic_req_valid || dc_req_valid) begin
        state_d = GRANT;
        owner_d = pick_dc;
        last_d = pick_dc;
        cnt_d = '0;
        addr_d = pick_dc ? dc_req_address : ic_req_address;
        type_d = pick_dc ? dc_req_type : ic_req_type;
        wdata_d = pick_dc ? dc_word_to_store : ic_word_to_store;
      end
      GRANT: begin
        cnt_d = (TO_EN && cnt_q != TMAX) ? cnt_q + 1'b1 : cnt_q;
        timeout_d = timeout_q || (TO_EN && cnt_d == TMAX);
        if (l2_fetched_word_valid) begin
          state_d = RESP;
          ic_word_d = owner_q ? ic_word_q : l2_fetched_word;
          dc_word_d = owner_q ? l2_fetched_word : dc_word_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b0;
      cnt_q <= '0;
      timeout_q <= 1'b0;
      addr_q <= '0;
      type_q <= LOAD;
      wdata_q <= '0;
      ic_word_q <= '0;
      dc_word_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
      addr_q <= addr_d;
      type_q <= type_d;
      wdata_q <= wdata_d;
      ic_word_q <= ic_word_d;
      dc_word_q <= dc_word_d;
    end
  end
  assign l2_req_valid = state_q == GRANT;
  assign ic_fetched_word_valid = state_q == RESP && !owner_q;
  assign dc_fetched_word_valid = state_q == RESP && owner_q;
  assign l2_req_address = addr_q;
  assign l2_req_type = type_q;
  assign l2_word_to_store = wdata_q;
  assign ic_fetched_word = ic_word_q;
  assign dc_fetched_word = dc_word_q;
  assign l2_timeout = timeout_q;
endmodule
